// File: rtl/btd_pkg.sv
// Shared definitions for the branch trace driver: FSM states, default widths, trace record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package btd_pkg;

  localparam int BTD_PC_W   = 9;
  localparam int BTD_ADDR_W = 8;
  localparam int BTD_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } btd_state_t;

  // One trace memory record as stored by the trace memory.
  typedef struct packed {
    logic [BTD_PC_W-1:0] pc;
    logic                taken;
  } btd_rec_t;

endpackage

// File: rtl/btd_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
// Latency: count reflects clr/inc one cycle after they are sampled.
// Backpressure: none; clr has priority over inc.
module btd_sat_counter
  import btd_pkg::*;
#(
  parameter int CNT_W = BTD_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count up on inc, clear on clr, hold once the maximum is reached.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/branch_trace_driver.sv
// Replays a stored {pc,taken} trace into a branch predictor and scores its predictions.
// Latency: first read 1 cycle after accepted start, first score 3 cycles after, done pulse len+3 cycles after.
// Backpressure: none, one record per cycle; start ignored while busy. Macro BTD_FIRST_MISS_EN adds first-mispredict capture.
module branch_trace_driver
  import btd_pkg::*;
#(
  parameter int PC_W   = BTD_PC_W,
  parameter int ADDR_W = BTD_ADDR_W,
  parameter int CNT_W  = BTD_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   trace_len,
  output logic              trace_rd_en,
  output logic [ADDR_W-1:0] trace_addr,
  input  logic [PC_W-1:0]   trace_pc,
  input  logic              trace_taken,
  output logic [PC_W-1:0]   pc,
  output logic              taken,
  output logic              bp_update,
  input  logic              prediction,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  total_predictions,
  output logic [CNT_W-1:0]  correct_predictions,
  output logic [CNT_W-1:0]  mispredicts,
  output logic              first_miss_valid,
  output logic [ADDR_W-1:0] first_miss_idx
);

  localparam logic [ADDR_W:0] RD_ONE = {{ADDR_W{1'b0}}, 1'b1};

  btd_state_t      state;
  btd_state_t      state_nxt;
  logic            clr;
  logic [ADDR_W:0] len_q;
  // One bit wider than the address so a full 2^ADDR_W trace does not wrap.
  logic [ADDR_W:0] rd_cnt;
  logic            rd_last;
  logic            mem_vld;
  logic            hit;

  assign rd_last     = ((rd_cnt + RD_ONE) == len_q);
  assign trace_rd_en = (state == ST_RUN);
  assign trace_addr  = rd_cnt[ADDR_W-1:0];
  assign busy        = (state == ST_RUN) || (state == ST_DRAIN);
  assign done        = (state == ST_DONE);
  assign hit         = (prediction == taken);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the counter clear strobe for an accepted start.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = (trace_len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (rd_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Last record is in SCORE and nothing is left in the memory stage.
        if (bp_update && !mem_vld) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latch the trace length and step the read address once per RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q  <= '0;
      rd_cnt <= '0;
    end else if ((state == ST_IDLE) && start) begin
      len_q  <= trace_len;
      rd_cnt <= '0;
    end else if ((state == ST_RUN) && !rd_last) begin
      rd_cnt <= rd_cnt + RD_ONE;
    end
  end

  // MEM and SCORE stages; pc/taken hold the last scored record between runs.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_vld   <= 1'b0;
      bp_update <= 1'b0;
      pc        <= '0;
      taken     <= 1'b0;
    end else begin
      mem_vld   <= trace_rd_en;
      bp_update <= mem_vld;
      if (mem_vld) begin
        pc    <= trace_pc;
        taken <= trace_taken;
      end
    end
  end

  btd_sat_counter #(.CNT_W(CNT_W)) u_total (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (bp_update),
    .count (total_predictions)
  );

  btd_sat_counter #(.CNT_W(CNT_W)) u_correct (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (bp_update && hit),
    .count (correct_predictions)
  );

  btd_sat_counter #(.CNT_W(CNT_W)) u_miss (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (bp_update && !hit),
    .count (mispredicts)
  );

`ifdef BTD_FIRST_MISS_EN
  logic [ADDR_W-1:0] mem_idx;
  logic [ADDR_W-1:0] score_idx;
  logic              fm_vld;
  logic [ADDR_W-1:0] fm_idx;

  // Carry the record index alongside the data through MEM and SCORE.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_idx   <= '0;
      score_idx <= '0;
    end else begin
      mem_idx <= trace_addr;
      if (mem_vld) score_idx <= mem_idx;
    end
  end

  // Sticky capture of the first mispredicted record index of a run.
  always_ff @(posedge clk) begin
    if (reset) begin
      fm_vld <= 1'b0;
      fm_idx <= '0;
    end else if (clr) begin
      fm_vld <= 1'b0;
      fm_idx <= '0;
    end else if (bp_update && !hit && !fm_vld) begin
      fm_vld <= 1'b1;
      fm_idx <= score_idx;
    end
  end

  assign first_miss_valid = fm_vld;
  assign first_miss_idx   = fm_idx;
`else
  assign first_miss_valid = 1'b0;
  assign first_miss_idx   = '0;
`endif

endmodule

// File: tb/tb_branch_trace_driver.sv
// Scoreboard bench: a reference model queues expected reads, scored records and final counts;
// a negedge monitor pops and compares whenever the DUT presents them.
// A second instance with 3-bit counters and prediction tied to taken exercises saturation.
module tb_branch_trace_driver;
  import btd_pkg::*;

  localparam int PC_W   = BTD_PC_W;
  localparam int ADDR_W = BTD_ADDR_W;
  localparam int CNT_W  = BTD_CNT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              start;
  logic [ADDR_W:0]   trace_len;
  logic              trace_rd_en;
  logic [ADDR_W-1:0] trace_addr;
  logic [PC_W-1:0]   trace_pc;
  logic              trace_taken;
  logic [PC_W-1:0]   pc;
  logic              taken;
  logic              bp_update;
  logic              prediction;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  total;
  logic [CNT_W-1:0]  correct;
  logic [CNT_W-1:0]  mis;
  logic              fm_vld;
  logic [ADDR_W-1:0] fm_idx;

  logic              s_rd_en;
  logic [ADDR_W-1:0] s_addr;
  logic [PC_W-1:0]   s_pc;
  logic              s_taken;
  logic              s_bp;
  logic              s_busy;
  logic              s_done;
  logic [2:0]        s_total;
  logic [2:0]        s_correct;
  logic [2:0]        s_mis;
  logic              s_fm_vld;
  logic [ADDR_W-1:0] s_fm_idx;

  branch_trace_driver dut (
    .clk(clk), .reset(reset), .start(start), .trace_len(trace_len),
    .trace_rd_en(trace_rd_en), .trace_addr(trace_addr),
    .trace_pc(trace_pc), .trace_taken(trace_taken),
    .pc(pc), .taken(taken), .bp_update(bp_update), .prediction(prediction),
    .busy(busy), .done(done),
    .total_predictions(total), .correct_predictions(correct), .mispredicts(mis),
    .first_miss_valid(fm_vld), .first_miss_idx(fm_idx)
  );

  branch_trace_driver #(.CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .start(start), .trace_len(trace_len),
    .trace_rd_en(s_rd_en), .trace_addr(s_addr),
    .trace_pc(trace_pc), .trace_taken(trace_taken),
    .pc(s_pc), .taken(s_taken), .bp_update(s_bp), .prediction(s_taken),
    .busy(s_busy), .done(s_done),
    .total_predictions(s_total), .correct_predictions(s_correct), .mispredicts(s_mis),
    .first_miss_valid(s_fm_vld), .first_miss_idx(s_fm_idx)
  );

  // Synchronous-read trace memory.
  btd_rec_t mem [0:255];
  btd_rec_t rd_q;
  always @(posedge clk) if (trace_rd_en) rd_q <= mem[trace_addr];
  assign trace_pc    = rd_q.pc;
  assign trace_taken = rd_q.taken;

  // Predictor environment: 1-bit last-outcome table per pc, or forced patterns.
  logic pred_tbl [0:511];
  int   mode;
  int   sc;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) pred_tbl[i] <= 1'b0;
      sc <= 0;
    end else begin
      if (bp_update) begin
        pred_tbl[pc] <= taken;
        sc <= sc + 1;
      end
      if (done) sc <= 0;
    end
  end
  assign prediction = (mode == 1) ? taken :
                      (mode == 2) ? (taken ^ (sc == 3)) : pred_tbl[pc];

  // Scoreboard state.
  typedef struct {
    int len;
    int total;
    int correct;
    int mis;
    int s_total;
    int s_correct;
    int s_mis;
  } done_t;

  logic [ADDR_W-1:0] exp_addr [$];
  btd_rec_t          exp_rec  [$];
  done_t             exp_done [$];
  bit                ref_tbl  [0:511];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: DUT presented an output with no expectation queued at %0t", nm, $time);
  endtask

  // Monitor: pop and compare whenever the DUT presents a read, a scored record or done.
  int        mon_bp = 0;
  btd_rec_t  m_rec;
  done_t     m_d;
  always @(negedge clk) begin
    if (trace_rd_en) begin
      if (exp_addr.size() == 0) unexpected("rd_strobe");
      else chk("trace_addr", trace_addr, exp_addr.pop_front());
    end
    if (bp_update) begin
      if (exp_rec.size() == 0) unexpected("bp_update");
      else begin
        m_rec = exp_rec.pop_front();
        chk("score_pc", pc, m_rec.pc);
        chk("score_taken", taken, m_rec.taken);
      end
      mon_bp++;
    end
    if (done) begin
      if (exp_done.size() == 0) unexpected("done");
      else begin
        m_d = exp_done.pop_front();
        chk("total", total, m_d.total);
        chk("correct", correct, m_d.correct);
        chk("mispredicts", mis, m_d.mis);
        chk("bp_update_count", mon_bp, m_d.len);
        chk("records_left", exp_rec.size(), 0);
        chk("sat_total", s_total, m_d.s_total);
        chk("sat_correct", s_correct, m_d.s_correct);
        chk("sat_mispredicts", s_mis, m_d.s_mis);
      end
      mon_bp = 0;
    end
    if (reset) mon_bp = 0;
  end

  // Reference model: fill the trace and derive expectations record by record.
  task automatic prep(input int len, input int m, input bit custom);
    done_t d;
    bit    p;
    d = '{len, 0, 0, 0, 0, 0, 0};
    for (int k = 0; k < len; k++) begin
      if (!custom) begin
        mem[k].pc    = PC_W'($urandom_range(0, 7));
        mem[k].taken = 1'($urandom_range(0, 1));
      end
      exp_addr.push_back(ADDR_W'(k));
      exp_rec.push_back(mem[k]);
      if (m == 1)      p = mem[k].taken;
      else if (m == 2) p = mem[k].taken ^ (k == 3);
      else             p = ref_tbl[mem[k].pc];
      if (p == mem[k].taken) d.correct++;
      else d.mis++;
      ref_tbl[mem[k].pc] = mem[k].taken;
    end
    d.total     = d.correct + d.mis;
    d.s_total   = (len > 7) ? 7 : len;
    d.s_correct = d.s_total;
    d.s_mis     = 0;
    exp_done.push_back(d);
    mode = m;
  endtask

  // Issue one replay (called #1 after a posedge) and check handshake timing.
  task automatic run(input int len, input int m, input bit custom, input bit mid);
    int cyc;
    int first_bp;
    bit seen;
    prep(len, m, custom);
    start     = 1'b1;
    trace_len = (ADDR_W+1)'(len);
    cyc = 0;
    first_bp = -1;
    seen = 1'b0;
    while (!seen && cyc < len + 20) begin
      @(posedge clk); #1;
      cyc++;
      start = mid && (cyc == 2);
      if (mid && cyc == 2) trace_len = 9'd5;
      if (bp_update && first_bp < 0) first_bp = cyc;
      if (done) seen = 1'b1;
    end
    chk("done_latency", cyc, (len == 0) ? 1 : len + 3);
    if (len > 0) chk("first_bp_latency", first_bp, 3);
    @(posedge clk); #1;
    chk("idle_bp_update", bp_update, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    if (len > 0) begin
      chk("idle_pc_hold", pc, mem[len-1].pc);
      chk("idle_taken_hold", taken, mem[len-1].taken);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_taken"}, taken, 0);
    chk({tag, "_rd_en"}, trace_rd_en, 0);
    chk({tag, "_addr"}, trace_addr, 0);
    chk({tag, "_bp_update"}, bp_update, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_total"}, total, 0);
    chk({tag, "_correct"}, correct, 0);
    chk({tag, "_mis"}, mis, 0);
    chk({tag, "_fm_vld"}, fm_vld, 0);
    chk({tag, "_fm_idx"}, fm_idx, 0);
  endtask

  initial begin
    int cnt;
    int cyc;
    bit saw_done;
    reset = 1'b1;
    start = 1'b0;
    trace_len = '0;
    mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed trace against a 1-bit last-outcome predictor starting at 0.
    mem[0] = '{pc: 9'd5, taken: 1'b1};
    mem[1] = '{pc: 9'd5, taken: 1'b1};
    mem[2] = '{pc: 9'd5, taken: 1'b0};
    mem[3] = '{pc: 9'd5, taken: 1'b0};
    run(4, 0, 1'b1, 1'b0);
    chk("directed_total", total, 4);
    chk("directed_correct", correct, 2);
    chk("directed_mis", mis, 2);

    // Zero-length replay: straight to done with cleared counters.
    run(0, 0, 1'b0, 1'b0);
    chk("len0_total", total, 0);

    // Start pulsed again mid-run must be ignored.
    run(8, 0, 1'b0, 1'b1);

    // Reset in the cycle after the second scored record aborts the replay.
    prep(6, 0, 1'b0);
    start = 1'b1;
    trace_len = 9'd6;
    cnt = 0;
    cyc = 0;
    while (cnt < 2 && cyc < 30) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (bp_update) cnt++;
    end
    chk("abort_bp_seen", cnt, 2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("abort");
    exp_addr.delete();
    exp_rec.delete();
    exp_done.delete();
    for (int i = 0; i < 512; i++) ref_tbl[i] = 1'b0;
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      saw_done = saw_done | done;
    end
    chk("abort_no_done", saw_done, 0);
    run(3, 0, 1'b0, 1'b0);
    chk("after_abort_total", total, 3);

    // Randomized replays, a perfect-predictor run and a full-depth trace.
    for (int r = 0; r < 6; r++) run($urandom_range(1, 20), 0, 1'b0, 1'b0);
    run(10, 1, 1'b0, 1'b0);
    chk("sat_total_len10", s_total, 7);
    chk("sat_mis_len10", s_mis, 0);
    run(256, 0, 1'b0, 1'b0);
    chk("full_depth_total", total, 256);

`ifdef BTD_FIRST_MISS_EN
    run(6, 2, 1'b0, 1'b0);
    chk("fm_valid", fm_vld, 1);
    chk("fm_idx", fm_idx, 3);
    repeat (3) @(posedge clk);
    #1;
    chk("fm_valid_held", fm_vld, 1);
    chk("fm_idx_held", fm_idx, 3);
    run(4, 1, 1'b0, 1'b0);
    chk("fm_cleared_on_start", fm_vld, 0);
`else
    chk("fm_valid_tied", fm_vld, 0);
    chk("fm_idx_tied", fm_idx, 0);
`endif

    repeat (2) @(posedge clk);
    chk("leftover_expectations", exp_addr.size() + exp_rec.size() + exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
